chime_scheduler: RTL and testbench

//  Schedules LED "chime" sequences for the BCD wall clock. Detects top-of-hour and midnight

---
 rtl/chime_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_chime_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chime_scheduler.sv
// chime_scheduler: queues top-of-hour, midnight and manual chime requests and
// plays them one at a time. A granted request blinks its LED(s) once per counted
// unit, then holds the LCD refresh window open.
//
// Ports:
//   CLK1K      - 1 kHz system clock
//   RST        - asynchronous reset, active-high
//   ENABLE     - chime function enable
//   SEG0..SEG7 - BCD time digits: sec1, sec10, min1, min10, hr1, hr10, day1, day10
//   MAN_REQ    - manual chime request (level, sampled each cycle)
//   MAN_COUNT  - blink count for the manual request, latched at grant
//   LEDG       - green LED (hour chime, manual chime)
//   LEDR       - red LED (day chime, manual chime)
//   LCD_EN     - LCD refresh window
//   BUSY       - a sequence is in progress
//   ACT_SRC    - active source: 0 none, 1 hour, 2 day, 3 manual
//   PEND       - pending flags {manual, day, hour}
module chime_scheduler #(
  parameter int unsigned HALF_PERIOD = 500,
  parameter int unsigned LCD_HOLD    = 10000
) (
  input  logic       CLK1K,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [3:0] SEG0,
  input  logic [3:0] SEG1,
  input  logic [3:0] SEG2,
  input  logic [3:0] SEG3,
  input  logic [3:0] SEG4,
  input  logic [3:0] SEG5,
  input  logic [3:0] SEG6,
  input  logic [3:0] SEG7,
  input  logic       MAN_REQ,
  input  logic [4:0] MAN_COUNT,
  output logic       LEDG,
  output logic       LEDR,
  output logic       LCD_EN,
  output logic       BUSY,
  output logic [1:0] ACT_SRC,
  output logic [2:0] PEND
);

  localparam int unsigned PMAX = (HALF_PERIOD > LCD_HOLD) ? HALF_PERIOD : LCD_HOLD;
  localparam int unsigned CW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LCD_LAST = CW'(LCD_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BLINK_ON, S_BLINK_OFF, S_LCD_WIN
  } state_t;

  // Two BCD digits to a blink count; malformed digits or values above 31 saturate.
  function automatic logic [4:0] bcd_count(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] v;
    logic [4:0] r;
    v = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    if (tens > 4'd9 || ones > 4'd9 || v > 8'd31) r = 5'd31;
    else                                         r = v[4:0];
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    pend_q, pend_d, pend_set, pend_clr;
  logic          top_q, top_d;
  logic [4:0]    rem_q, rem_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [1:0]    act_q, act_d;
  logic          ledg_q, ledg_d, ledr_q, ledr_d, lcd_q, lcd_d, busy_q, busy_d;
  logic          top_rise, midnight;

  always_comb begin
    top_d    = (SEG0 == 4'd0) && (SEG1 == 4'd0) && (SEG2 == 4'd0) && (SEG3 == 4'd0);
    top_rise = top_d && !top_q && ENABLE;
    midnight = (SEG4 == 4'd0) && (SEG5 == 4'd0);
    pend_set = {MAN_REQ && ENABLE, top_rise && midnight, top_rise && !midnight};

    pend_clr = '0;
    state_d  = state_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    act_d    = act_q;

    case (state_q)
      S_IDLE: begin
        if (ENABLE && (|pend_q)) begin
          state_d = S_LOAD;
          if (pend_q[1]) begin
            pend_clr = 3'b010;
            act_d    = 2'd2;
            rem_d    = bcd_count(SEG7, SEG6);
          end else if (pend_q[0]) begin
            pend_clr = 3'b001;
            act_d    = 2'd1;
            rem_d    = bcd_count(SEG5, SEG4);
          end else begin
            pend_clr = 3'b100;
            act_d    = 2'd3;
            rem_d    = MAN_COUNT;
          end
        end
      end
      S_LOAD: begin
        phase_d = '0;
        state_d = (rem_q == 5'd0) ? S_LCD_WIN : S_BLINK_ON;
      end
      S_BLINK_ON: begin
        if (phase_q == HP_LAST) begin
          phase_d = '0;
          state_d = S_BLINK_OFF;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_BLINK_OFF: begin
        if (phase_q == HP_LAST) begin
          phase_d = '0;
          rem_d   = rem_q - 5'd1;
          state_d = (rem_q == 5'd1) ? S_LCD_WIN : S_BLINK_ON;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_LCD_WIN: begin
        if (phase_q == LCD_LAST) begin
          phase_d = '0;
          act_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        act_d   = 2'd0;
      end
    endcase

    // Losing ENABLE abandons the active request; its pend bit was already cleared at grant.
    if (!ENABLE && state_q != S_IDLE) begin
      state_d = S_IDLE;
      act_d   = 2'd0;
      phase_d = '0;
    end

    // A set arriving on the grant edge survives that grant's clear.
    pend_d = (pend_q & ~pend_clr) | pend_set;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    ledg_d = (state_d == S_BLINK_ON) && (act_d == 2'd1 || act_d == 2'd3);
    ledr_d = (state_d == S_BLINK_ON) && (act_d == 2'd2 || act_d == 2'd3);
    lcd_d  = (state_d == S_LCD_WIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      top_q   <= 1'b0;
      rem_q   <= '0;
      phase_q <= '0;
      act_q   <= '0;
      ledg_q  <= 1'b0;
      ledr_q  <= 1'b0;
      lcd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      top_q   <= top_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      act_q   <= act_d;
      ledg_q  <= ledg_d;
      ledr_q  <= ledr_d;
      lcd_q   <= lcd_d;
      busy_q  <= busy_d;
    end
  end

  assign LEDG    = ledg_q;
  assign LEDR    = ledr_q;
  assign LCD_EN  = lcd_q;
  assign BUSY    = busy_q;
  assign ACT_SRC = act_q;
  assign PEND    = pend_q;

endmodule

// File: tb/tb_chime_scheduler.sv
module tb_chime_scheduler;

  localparam int HP  = 3;
  localparam int LCD = 8;

  logic       CLK1K = 1'b0;
  logic       RST = 1'b1;
  logic       ENABLE = 1'b1;
  logic [3:0] SEG0 = 4'd9, SEG1 = 4'd0, SEG2 = 4'd0, SEG3 = 4'd0;
  logic [3:0] SEG4 = 4'd0, SEG5 = 4'd0, SEG6 = 4'd0, SEG7 = 4'd0;
  logic       MAN_REQ = 1'b0;
  logic [4:0] MAN_COUNT = 5'd0;
  logic       LEDG, LEDR, LCD_EN, BUSY;
  logic [1:0] ACT_SRC;
  logic [2:0] PEND;

  chime_scheduler #(.HALF_PERIOD(HP), .LCD_HOLD(LCD)) dut (
    .CLK1K(CLK1K), .RST(RST), .ENABLE(ENABLE),
    .SEG0(SEG0), .SEG1(SEG1), .SEG2(SEG2), .SEG3(SEG3),
    .SEG4(SEG4), .SEG5(SEG5), .SEG6(SEG6), .SEG7(SEG7),
    .MAN_REQ(MAN_REQ), .MAN_COUNT(MAN_COUNT),
    .LEDG(LEDG), .LEDR(LEDR), .LCD_EN(LCD_EN), .BUSY(BUSY),
    .ACT_SRC(ACT_SRC), .PEND(PEND)
  );

  always #5 CLK1K = ~CLK1K;

  // Expected completed sequence: source, number of blinks, which LEDs ({LEDR,LEDG}) lit.
  typedef struct {
    logic [1:0] src;
    int         pulses;
    logic [1:0] leds;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  // Sequence monitor: measures each blink and the LCD window, pops the scoreboard at window end.
  int m_hi = 0, m_lo = 0, m_pulses = 0, m_lcd = 0;
  logic [1:0] m_src = 2'd0, m_leds = 2'b00;
  logic prev_led = 1'b0;

  always @(negedge CLK1K) begin
    if (m_lcd > 0 && !LCD_EN) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got sequence src %0d pulses %0d, want none", m_src, m_pulses);
      end else begin
        e = sb.pop_front();
        if (m_src !== e.src) begin
          miscompares++;
          $display("FAIL seq_src: got %0d want %0d", m_src, e.src);
        end
        vectors++;
        if (m_pulses != e.pulses) begin
          miscompares++;
          $display("FAIL seq_pulses: got %0d want %0d", m_pulses, e.pulses);
        end
        vectors++;
        if (m_leds !== e.leds) begin
          miscompares++;
          $display("FAIL seq_leds: got %b want %b", m_leds, e.leds);
        end
        vectors++;
        if (m_lcd != LCD) begin
          miscompares++;
          $display("FAIL seq_lcd_len: got %0d want %0d", m_lcd, LCD);
        end
      end
      m_hi = 0; m_lo = 0; m_pulses = 0; m_lcd = 0; m_src = 2'd0; m_leds = 2'b00; prev_led = 1'b0;
    end else if (RST || !BUSY) begin
      m_hi = 0; m_lo = 0; m_pulses = 0; m_lcd = 0; m_src = 2'd0; m_leds = 2'b00; prev_led = 1'b0;
    end else begin
      if (ACT_SRC != 2'd0) m_src = ACT_SRC;
      if (LEDG || LEDR) begin
        if (!prev_led && m_pulses > 0) begin
          vectors++;
          if (m_lo != HP) begin
            miscompares++;
            $display("FAIL blink_low_len: got %0d want %0d", m_lo, HP);
          end
        end
        m_hi++;
        m_leds = m_leds | {LEDR, LEDG};
      end else if (prev_led) begin
        m_pulses++;
        vectors++;
        if (m_hi != HP) begin
          miscompares++;
          $display("FAIL blink_high_len: got %0d want %0d", m_hi, HP);
        end
        m_hi = 0;
        m_lo = 1;
      end else begin
        m_lo++;
      end
      if (LCD_EN) m_lcd++;
      prev_led = LEDG || LEDR;
    end
  end

  // Present a non-top time with the given hour/day digits, then roll seconds/minutes to zero.
  task automatic fire_top(input logic [3:0] h10, input logic [3:0] h1,
                          input logic [3:0] d10, input logic [3:0] d1, input logic man);
    @(negedge CLK1K);
    SEG0 = 4'd9; SEG1 = 4'd0; SEG2 = 4'd0; SEG3 = 4'd0;
    SEG4 = h1; SEG5 = h10; SEG6 = d1; SEG7 = d10;
    @(negedge CLK1K);
    SEG0 = 4'd0;
    MAN_REQ = man;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK1K);
      if (sb.size() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK1K);
    vectors++;
    if ({LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", {LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND}, 9'b0);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK1K);
    vectors++;
    if ({BUSY, PEND} !== 4'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want %b", {BUSY, PEND}, 4'b0);
    end
  endtask

  task automatic test_hour_chime;
    bit ok;
    sb.push_back('{2'd1, 14, 2'b01});
    fire_top(4'd1, 4'd4, 4'd0, 4'd1, 1'b0);
    @(negedge CLK1K);
    vectors++;
    if ({BUSY, ACT_SRC, PEND} !== 6'b0_00_001) begin
      miscompares++;
      $display("FAIL hour_pend: got %b want %b", {BUSY, ACT_SRC, PEND}, 6'b0_00_001);
    end
    @(negedge CLK1K);
    vectors++;
    if ({BUSY, ACT_SRC, PEND, LEDG} !== 7'b1_01_000_0) begin
      miscompares++;
      $display("FAIL hour_grant: got %b want %b", {BUSY, ACT_SRC, PEND, LEDG}, 7'b1_01_000_0);
    end
    @(negedge CLK1K);
    vectors++;
    if ({LEDG, LEDR} !== 2'b10) begin
      miscompares++;
      $display("FAIL hour_first_led: got %b want %b", {LEDG, LEDR}, 2'b10);
    end
    wait_done(2000, ok);
    vectors++;
    if (!ok || {BUSY, ACT_SRC, LCD_EN} !== 4'b0) begin
      miscompares++;
      $display("FAIL hour_done: got done=%0d busy/src/lcd=%b want done=1 %b", ok, {BUSY, ACT_SRC, LCD_EN}, 4'b0);
    end
  endtask

  task automatic test_day_chime;
    bit ok;
    sb.push_back('{2'd2, 7, 2'b10});
    fire_top(4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
    @(negedge CLK1K);
    vectors++;
    if (PEND !== 3'b010) begin
      miscompares++;
      $display("FAIL day_pend: got %b want %b", PEND, 3'b010);
    end
    @(negedge CLK1K);
    vectors++;
    if ({ACT_SRC, PEND} !== 5'b10_000) begin
      miscompares++;
      $display("FAIL day_grant: got %b want %b", {ACT_SRC, PEND}, 5'b10_000);
    end
    wait_done(2000, ok);
    vectors++;
    if (!ok || PEND !== 3'b000) begin
      miscompares++;
      $display("FAIL day_done: got done=%0d pend=%b want done=1 pend=000", ok, PEND);
    end
  endtask

  task automatic test_priority;
    bit ok, seen;
    MAN_COUNT = 5'd3;
    sb.push_back('{2'd2, 12, 2'b10});
    sb.push_back('{2'd3, 3, 2'b11});
    fire_top(4'd0, 4'd0, 4'd1, 4'd2, 1'b1);
    @(negedge CLK1K);
    MAN_REQ = 1'b0;
    vectors++;
    if (PEND !== 3'b110) begin
      miscompares++;
      $display("FAIL prio_pend: got %b want %b", PEND, 3'b110);
    end
    @(negedge CLK1K);
    vectors++;
    if ({ACT_SRC, PEND} !== 5'b10_100) begin
      miscompares++;
      $display("FAIL prio_day_first: got %b want %b", {ACT_SRC, PEND}, 5'b10_100);
    end
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK1K);
      if (LCD_EN) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || {BUSY, ACT_SRC} !== 3'b0_00) begin
      miscompares++;
      $display("FAIL prio_idle_gap: got done=%0d busy/src=%b want done=1 %b", ok, {BUSY, ACT_SRC}, 3'b0_00);
    end
    @(negedge CLK1K);
    vectors++;
    if ({BUSY, ACT_SRC, PEND} !== 6'b1_11_000) begin
      miscompares++;
      $display("FAIL prio_manual_next: got %b want %b", {BUSY, ACT_SRC, PEND}, 6'b1_11_000);
    end
    wait_done(2000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL prio_done: got timeout want completion");
    end
  endtask

  task automatic test_zero_count;
    bit ok;
    MAN_COUNT = 5'd0;
    sb.push_back('{2'd3, 0, 2'b00});
    @(negedge CLK1K);
    MAN_REQ = 1'b1;
    @(negedge CLK1K);
    MAN_REQ = 1'b0;
    vectors++;
    if (PEND !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_pend: got %b want %b", PEND, 3'b100);
    end
    @(negedge CLK1K);
    vectors++;
    if ({BUSY, ACT_SRC, LCD_EN} !== 4'b1_11_0) begin
      miscompares++;
      $display("FAIL zero_load: got %b want %b", {BUSY, ACT_SRC, LCD_EN}, 4'b1_11_0);
    end
    @(negedge CLK1K);
    vectors++;
    if ({LCD_EN, LEDG, LEDR} !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_lcd_start: got %b want %b", {LCD_EN, LEDG, LEDR}, 3'b100);
    end
    wait_done(500, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL zero_done: got timeout want completion");
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    int rises;
    logic prev;
    fire_top(4'd1, 4'd4, 4'd0, 4'd1, 1'b0);
    @(negedge CLK1K);
    @(negedge CLK1K);
    MAN_COUNT = 5'd2;
    MAN_REQ = 1'b1;
    @(negedge CLK1K);
    MAN_REQ = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 1000 && rises < 5; i++) begin
      @(negedge CLK1K);
      if (LEDG && !prev) rises++;
      prev = LEDG;
    end
    vectors++;
    if (rises != 5) begin
      miscompares++;
      $display("FAIL drop_reach_pulse5: got %0d pulses want 5", rises);
    end
    ENABLE = 1'b0;
    @(negedge CLK1K);
    vectors++;
    if ({LEDG, LEDR, LCD_EN, ACT_SRC, BUSY, PEND} !== 9'b0_0_0_00_0_100) begin
      miscompares++;
      $display("FAIL drop_next_edge: got %b want %b", {LEDG, LEDR, LCD_EN, ACT_SRC, BUSY, PEND}, 9'b0_0_0_00_0_100);
    end
    repeat (10) @(negedge CLK1K);
    vectors++;
    if ({BUSY, PEND} !== 4'b0_100) begin
      miscompares++;
      $display("FAIL drop_hold: got %b want %b", {BUSY, PEND}, 4'b0_100);
    end
    sb.push_back('{2'd3, 2, 2'b11});
    ENABLE = 1'b1;
    @(negedge CLK1K);
    vectors++;
    if ({ACT_SRC, PEND} !== 5'b11_000) begin
      miscompares++;
      $display("FAIL drop_resume_manual: got %b want %b", {ACT_SRC, PEND}, 5'b11_000);
    end
    wait_done(1000, ok);
    repeat (10) @(negedge CLK1K);
    vectors++;
    if (!ok || {BUSY, PEND} !== 4'b0) begin
      miscompares++;
      $display("FAIL drop_no_resume: got done=%0d busy/pend=%b want done=1 %b", ok, {BUSY, PEND}, 4'b0);
    end
  endtask

  task automatic test_saturation;
    bit ok;
    sb.push_back('{2'd1, 31, 2'b01});
    fire_top(4'd3, 4'd9, 4'd0, 4'd1, 1'b0);
    wait_done(5000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sat_hour_done: got timeout want completion");
    end
    sb.push_back('{2'd2, 31, 2'b10});
    fire_top(4'd0, 4'd0, 4'd0, 4'd10, 1'b0);
    wait_done(5000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sat_day_done: got timeout want completion");
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    fire_top(4'd1, 4'd4, 4'd0, 4'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK1K);
      if (LEDG) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rst_mid_reach_on: got no LED want LEDG high");
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND} !== 9'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %b want %b", {LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND}, 9'b0);
    end
    SEG0 = 4'd9;
    @(negedge CLK1K);
    RST = 1'b0;
    repeat (5) @(negedge CLK1K);
    vectors++;
    if ({LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND} !== 9'b0) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %b want %b", {LEDG, LEDR, LCD_EN, BUSY, ACT_SRC, PEND}, 9'b0);
    end
  endtask

  initial begin
    test_reset();
    test_hour_chime();
    test_day_chime();
    test_priority();
    test_zero_count();
    test_enable_drop();
    test_saturation();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d queued want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
